// File: rtl/mem_port_sched_pkg.sv
// Shared constants, lock state type and round-robin pointer helper for mem_port_sched.
package mem_sched_pkg;

  localparam int REQ_WIDTH = 10;
  localparam int AW        = 8;
  localparam int DW        = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Pointer after a transfer by idx; an out-of-range idx leaves ptr untouched.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned idx,
                                          input int unsigned n = REQ_WIDTH);
    if (idx >= n) return ptr;
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester-side and memory-side bus of the shared bank port.
interface mem_port_sched_if #(
  parameter int REQ_WIDTH = 10,
  parameter int AW        = 8,
  parameter int DW        = 32
);
  // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i];
  // the requester holds valid/lock/we/addr/wdata stable until that cycle, and
  // req_ready may depend combinationally on req_valid and mem_ready.
  logic [REQ_WIDTH-1:0]    req_valid;
  logic [REQ_WIDTH-1:0]    req_lock;
  logic [REQ_WIDTH-1:0]    req_we;
  logic [REQ_WIDTH*AW-1:0] req_addr;
  logic [REQ_WIDTH*DW-1:0] req_wdata;
  logic [REQ_WIDTH-1:0]    req_ready;
  logic [REQ_WIDTH-1:0]    rsp_valid;
  logic [DW-1:0]           rsp_rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [DW-1:0]           mem_rdata;
  logic                    mem_ready;

  modport master (
    output req_valid, req_lock, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_lock, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_sched_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first set req at or after ptr.
module rr_pick #(
  parameter int N  = 10,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  localparam int W2 = 2 * N;

  logic [W2-1:0] dbl, ptr_oh, masked, lowest;

  always_comb begin
    dbl    = {req, req};
    ptr_oh = W2'(1) << ptr;
    // Clearing the bits below ptr in the doubled vector makes the wrap-around
    // requesters appear in the upper copy, so a plain lowest-set-bit pick works.
    masked = dbl & ~(ptr_oh - W2'(1));
    lowest = masked & (~masked + W2'(1));
    grant  = lowest[N-1:0] | lowest[W2-1:N];
  end
endmodule

// File: rtl/mem_port_sched.sv
// Round-robin scheduler for one shared memory bank port with burst locking and tagged reads.
// Define MEM_PORT_SCHED_STATS_EN to add grant/conflict counters with a synchronous clear.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int REQ_WIDTH = mem_sched_pkg::REQ_WIDTH,
  parameter int AW        = mem_sched_pkg::AW,
  parameter int DW        = mem_sched_pkg::DW,
  parameter int RD_LAT    = 1,
  parameter int LOCK_MAX  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_sched_if.slave  bus,
  output logic             lock_active,
  output lock_state_e      dbg_lock_state
`ifdef MEM_PORT_SCHED_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_grants,
  output logic [31:0]      stat_conflicts
`endif
);
  localparam int PW = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  lock_state_e          lock_q, lock_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [REQ_WIDTH-1:0] cmd_tag_q, cmd_tag_d;
  logic [REQ_WIDTH-1:0] tag_pipe_q [RD_LAT];
  logic [REQ_WIDTH-1:0] tag_pipe_d [RD_LAT];

  logic [REQ_WIDTH-1:0] owner_oh, eligible, grant;
  logic [PW-1:0]        win_idx;
  logic                 xfer;

  always_comb begin
    owner_oh = REQ_WIDTH'(1) << owner_q;
    eligible = bus.req_valid & ((lock_q == LOCKED) ? owner_oh : '1)
             & {REQ_WIDTH{bus.mem_ready}};
  end

  rr_pick #(.N(REQ_WIDTH), .PW(PW)) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    xfer    = |grant;
    win_idx = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  // Lock FSM; a busy port (mem_ready=0) freezes state and count.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (bus.mem_ready) begin
      case (lock_q)
        IDLE: begin
          if (xfer && bus.req_lock[win_idx]) begin
            lock_d  = LOCKED;
            owner_d = win_idx;
            cnt_d   = 8'd1;
          end
        end
        LOCKED: begin
          if (!bus.req_valid[owner_q]) begin
            lock_d = IDLE;
            cnt_d  = '0;
          end else if (xfer) begin
            if (cnt_q >= 8'(LOCK_MAX) || !bus.req_lock[owner_q]) begin
              lock_d = IDLE;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: lock_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ptr_d       = xfer ? PW'(rr_next(32'(ptr_q), 32'(win_idx), REQ_WIDTH)) : ptr_q;
    mem_en_d    = xfer;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_tag_d   = cmd_tag_q;
    if (xfer) begin
      mem_we_d    = bus.req_we[win_idx];
      mem_addr_d  = bus.req_addr[win_idx*AW +: AW];
      mem_wdata_d = bus.req_wdata[win_idx*DW +: DW];
      cmd_tag_d   = grant;
    end
    tag_pipe_d[0] = (mem_en_q && !mem_we_q) ? cmd_tag_q : '0;
    for (int k = 1; k < RD_LAT; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      lock_q      <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_tag_q   <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_pipe_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_tag_q   <= cmd_tag_d;
      for (int k = 0; k < RD_LAT; k++) tag_pipe_q[k] <= tag_pipe_d[k];
    end
  end

  assign bus.req_ready   = grant;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rsp_valid   = tag_pipe_q[RD_LAT-1];
  assign bus.rsp_rdata   = bus.mem_rdata;
  assign lock_active     = (lock_q == LOCKED);
  assign dbg_lock_state  = lock_q;

`ifdef MEM_PORT_SCHED_STATS_EN
  logic [31:0] grants_q, grants_d, conf_q, conf_d;
  logic        conflict;

  always_comb begin
    conflict = ($countones(bus.req_valid) > 1)
             || ((|bus.req_valid) && !bus.mem_ready)
             || ((lock_q == LOCKED) && (|(bus.req_valid & ~owner_oh)));
    grants_d = grants_q;
    conf_d   = conf_q;
    if (stat_clr) begin
      grants_d = '0;
      conf_d   = '0;
    end else begin
      if (xfer && grants_q != '1)   grants_d = grants_q + 32'd1;
      if (conflict && conf_q != '1) conf_d   = conf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grants_q <= '0;
      conf_q   <= '0;
    end else begin
      grants_q <= grants_d;
      conf_q   <= conf_d;
    end
  end

  assign stat_grants    = grants_q;
  assign stat_conflicts = conf_q;
`endif

endmodule
